// File: rtl/pdm_modulator.sv
// PCM-to-PDM transmitter: zero-order-holds 16-bit PCM samples for 2^OSR_LOG2 PDM bits
// and converts them into a 1-bit stream with a saturating second-order sigma-delta loop.
`timescale 1ns/1ps
module pdm_modulator #(
    parameter int CLK_DIV  = 32,
    parameter int OSR_LOG2 = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [15:0] s_tdata_i,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    output logic        pdm_clk_o,
    output logic        pdm_data_o,
    output logic        pdm_sd_o,
    output logic        fs_o,
    output logic        underrun_o
);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [OSR_LOG2-1:0] bit_q, bit_d;
    logic signed [15:0]  cur_q, cur_d;
    logic [15:0]         nxt_q, nxt_d;
    logic                nxt_v_q, nxt_v_d;
    logic signed [19:0]  i1_q, i1_d;
    logic signed [23:0]  i2_q, i2_d;
    logic                y_q, y_d;
    logic                pclk_q, pclk_d;
    logic                fs_q, fs_d;
    logic                ur_q, ur_d;
    logic                sd_q;

    logic                tick, boundary, accept;
    logic signed [15:0]  cur_sh;
    logic signed [16:0]  xs;
    logic signed [21:0]  fb22, sum1;
    logic signed [25:0]  fb26, sum2;
    logic signed [19:0]  i1_n;
    logic signed [23:0]  i2_n;

    function automatic logic signed [19:0] sat20(input logic signed [21:0] v);
        if (v > 22'sd524287)
            return 20'sh7FFFF;
        else if (v < -22'sd524288)
            return 20'sh80000;
        else
            return v[19:0];
    endfunction

    function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
        if (v > 26'sd8388607)
            return 24'sh7FFFFF;
        else if (v < -26'sd8388608)
            return 24'sh800000;
        else
            return v[23:0];
    endfunction

    // Ready is forced low while reset is held so every output reads 0 during reset.
    assign s_tready_o = en_i & ~nxt_v_q & rst_i;
    assign accept     = s_tvalid_i & s_tready_o;
    assign tick       = en_i && (div_q == DIV_W'(CLK_DIV - 1));
    assign boundary   = tick && (bit_q == '1);

    // Loop input is 0.75*cur so the integrators stay bounded at full-scale input.
    assign cur_sh = cur_q >>> 2;
    assign xs     = {cur_q[15], cur_q} - {cur_sh[15], cur_sh};
    assign fb22   = y_q ? 22'sd32768 : -22'sd32768;
    assign fb26   = y_q ? 26'sd32768 : -26'sd32768;
    assign sum1   = {{2{i1_q[19]}}, i1_q} + {{5{xs[16]}}, xs} - fb22;
    assign i1_n   = sat20(sum1);
    assign sum2   = {{2{i2_q[23]}}, i2_q} + {{6{i1_n[19]}}, i1_n} - fb26;
    assign i2_n   = sat24(sum2);

    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        nxt_v_d = nxt_v_q;
        i1_d    = i1_q;
        i2_d    = i2_q;
        y_d     = y_q;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        if (!en_i) begin
            div_d   = '0;
            bit_d   = '0;
            cur_d   = '0;
            nxt_v_d = 1'b0;
            i1_d    = '0;
            i2_d    = '0;
            y_d     = 1'b0;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                bit_d = bit_q + OSR_LOG2'(1);
                i1_d  = i1_n;
                i2_d  = i2_n;
                y_d   = ~i2_n[23];
            end
            if (boundary) begin
                fs_d = 1'b1;
                if (nxt_v_q) begin
                    cur_d   = nxt_q;
                    nxt_v_d = 1'b0;
                end else begin
                    ur_d = 1'b1;
                end
            end
            if (accept) begin
                nxt_d   = s_tdata_i;
                nxt_v_d = 1'b1;
            end
        end
        pclk_d = (div_d >= DIV_W'(CLK_DIV / 2));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q   <= '0;
            bit_q   <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
            nxt_v_q <= 1'b0;
            i1_q    <= '0;
            i2_q    <= '0;
            y_q     <= 1'b0;
            pclk_q  <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            nxt_v_q <= nxt_v_d;
            i1_q    <= i1_d;
            i2_q    <= i2_d;
            y_q     <= y_d;
            pclk_q  <= pclk_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
            sd_q    <= en_i;
        end
    end

    assign pdm_clk_o  = pclk_q;
    assign pdm_data_o = y_q;
    assign pdm_sd_o   = sd_q;
    assign fs_o       = fs_q;
    assign underrun_o = ur_q;

endmodule

// File: doc/pdm_modulator.md
# pdm_modulator

PCM-to-PDM transmitter for the audio output path, the opposite direction of the microphone decimation chain. It accepts 16-bit signed PCM samples through a valid/ready handshake and holds each sample for OSR bit periods (zero-order hold). A second-order sigma-delta modulator converts the held sample into a 1-bit PDM stream. The block drives the PDM bit clock, the PDM data line and the amplifier shutdown pin, all from the single system clock.

## Interface

Parameters:
- CLK_DIV, 32: clk_i cycles per PDM bit. Even, ≥4.
- OSR_LOG2, 6: log2 of PDM bits per PCM sample (64).

Ports:
- clk_i  in  1  system clock (100 MHz)
- rst_i  in  1  asynchronous, active-low reset
- en_i  in  1  block enable
- s_tdata_i  in  16  PCM sample, two's complement
- s_tvalid_i  in  1  sample valid
- s_tready_o  out  1  sample ready
- pdm_clk_o  out  1  PDM bit clock to the amplifier/filter
- pdm_data_o  out  1  PDM data bit
- pdm_sd_o  out  1  amplifier enable (0 = shutdown)
- fs_o  out  1  one-cycle pulse at each sample boundary
- underrun_o  out  1  one-cycle pulse when a boundary finds no new sample

## Operation

- Reset: every register is cleared, and every output is 0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - pdm_clk_o = 1 when div_cnt ≥ CLK_DIV/2, else 0.
  - The tick is the cycle where div_cnt == CLK_DIV-1.
- Bit counter: bit_cnt counts 0..2^OSR_LOG2-1 and advances on each tick. A boundary is a tick with bit_cnt at its maximum.
- Buffering: a current register cur plus a one-entry holding register nxt with flag nxt_v.
  - s_tready_o = en_i & ~nxt_v.
  - On s_tvalid_i & s_tready_o: nxt ← s_tdata_i and nxt_v ← 1.
- At a boundary:
  - fs_o pulses.
  - If nxt_v = 1: cur ← nxt and nxt_v ← 0. If an accept happens in the same cycle, nxt_v stays 1 with the new data.
  - Otherwise cur is held and underrun_o pulses.
- Modulator: updates only on a tick, using the pre-boundary value of cur.
  - Scaling: xs = cur − (cur >>> 2), i.e. 0.75·cur, 17-bit signed. This keeps the loop stable.
  - Feedback: fb = +32768 if y = 1, else −32768. y is the registered output bit.
  - i1 is 20-bit signed: i1' = sat20(i1 + xs − fb).
  - i2 is 24-bit signed: i2' = sat24(i2 + i1' − fb).
  - Output: y' = (i2' ≥ 0), and pdm_data_o = y.
  - Saturation clamps to the signed extremes of the target width; there is no wrap.
- Enable:
  - en_i = 0 holds div_cnt, bit_cnt, i1, i2, y, cur and nxt_v at 0.
  - pdm_clk_o and pdm_data_o are then 0, and s_tready_o is 0.
  - pdm_sd_o is en_i registered (one-cycle delay).
  - When en_i rises, the first tick occurs CLK_DIV cycles later.

## Timing

- pdm_data_o changes on the clock edge after a tick, coincident with pdm_clk_o falling. It is therefore stable for CLK_DIV/2 cycles before pdm_clk_o rises.
- With defaults: pdm_clk_o = 3.125 MHz and fs = 48.83 kHz.
- Latency: a sample accepted before boundary N is loaded at N. Its first modulator bit appears on the tick after N.
- The handshake never drops or duplicates an accepted sample. The upstream sees at most two samples in flight (cur and nxt).
- Reset asserted mid-stream: all outputs drop to 0 asynchronously, and no pending sample survives.
- en_i falling mid-sample: everything clears on the next clk_i edge.

## Test plan

- Zero input, en_i = 1, continuous valid: over 1024 ticks, pdm_data_o has 512 ± 2 ones. fs_o period is 2048 cycles, and underrun_o never pulses.
- Constant input +16384 (xs = 12288): over 4096 ticks, 2816 ± 8 ones (density 0.6875). Input −32768: density 0.125 ± 0.005, with no saturation lockup.
- Handshake: three samples offered back-to-back after reset.
  - The first is accepted, and s_tready_o drops.
  - The second waits until the first boundary, where the first moves to cur.
  - fs_o aligns with bit_cnt = 63 ticks.
- Underrun: stop s_tvalid_i. The next boundary pulses underrun_o for 1 cycle, cur keeps its last value, and pdm_data_o density is unchanged.
- Clock timing: pdm_clk_o period is 32 cycles with 16 high. pdm_data_o transitions only on the cycle after div_cnt = 31. The first tick comes 32 cycles after en_i rises.
- Reset/enable mid-stream:
  - Assert rst_i low mid-sample: all outputs are 0 immediately. After release, s_tready_o = 0 until en_i is seen.
  - Toggle en_i low for 1 cycle: integrators clear and pdm_sd_o drops one cycle later.
